tw_master_burst: RTL

//  Synthesizable 3-wire burst master, the initiator end of the USB-3W link. It drives
//  tw_bus_clock, tw_bus_chipselect (active-low) and the shared data line (split pins;

---
 rtl/tw_master_burst_if.sv | 43 ++++
 rtl/tw_master_burst.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tw_master_burst_if.sv
// Command, write-data, read-data and 3-wire pin bundle of the burst master.
// The master modport is the master block itself; the slave modport is its environment.
interface tw_master_burst_if #(
  parameter int TWS_ADDRESS_BITS       = 10,
  parameter int TWS_DATA_BITS          = 32,
  parameter int TWS_ADDRESS_BITS_WIDTH = 5,
  parameter int TWS_DATA_BITS_WIDTH    = 6,
  parameter int LEN_WIDTH              = 8
) ();
  logic [TWS_ADDRESS_BITS_WIDTH:0] addr_bits;
  logic [TWS_DATA_BITS_WIDTH:0]    data_bits;
  logic                            cmd_valid;
  logic                            cmd_ready;
  logic                            cmd_wr;
  logic [TWS_ADDRESS_BITS-1:0]     cmd_addr;
  logic [LEN_WIDTH-1:0]            cmd_len;
  logic [TWS_DATA_BITS-1:0]        wr_data;
  logic                            wr_data_valid;
  logic                            wr_data_ready;
  logic [TWS_DATA_BITS-1:0]        rd_data;
  logic                            rd_data_valid;
  logic                            busy;
  logic                            done;
  logic                            tw_bus_clock;
  logic                            tw_bus_chipselect;
  logic                            tw_bus_data_out;
  logic                            tw_bus_data_oe;
  logic                            tw_bus_data_in;

  modport master (
    input  addr_bits, data_bits, cmd_valid, cmd_wr, cmd_addr, cmd_len,
           wr_data, wr_data_valid, tw_bus_data_in,
    output cmd_ready, wr_data_ready, rd_data, rd_data_valid, busy, done,
           tw_bus_clock, tw_bus_chipselect, tw_bus_data_out, tw_bus_data_oe
  );

  modport slave (
    output addr_bits, data_bits, cmd_valid, cmd_wr, cmd_addr, cmd_len,
           wr_data, wr_data_valid, tw_bus_data_in,
    input  cmd_ready, wr_data_ready, rd_data, rd_data_valid, busy, done,
           tw_bus_clock, tw_bus_chipselect, tw_bus_data_out, tw_bus_data_oe
  );
endinterface

// File: rtl/tw_master_burst.sv
// 3-wire burst master: mode bit, address and N data words MSB-first over a
// divided bus clock, with write-data stall and per-word read reporting.
module tw_master_burst #(
  parameter int TWS_ADDRESS_BITS       = 10,
  parameter int TWS_DATA_BITS          = 32,
  parameter int TWS_ADDRESS_BITS_WIDTH = 5,
  parameter int TWS_DATA_BITS_WIDTH    = 6,
  parameter int CLK_DIV                = 4,
  parameter int LEN_WIDTH              = 8
) (
  input  logic              in_clk,
  input  logic              in_reset,
  tw_master_burst_if.master bus
);
  localparam int AW  = TWS_ADDRESS_BITS;
  localparam int DW  = TWS_DATA_BITS;
  localparam int ABW = TWS_ADDRESS_BITS_WIDTH + 1;
  localparam int DBW = TWS_DATA_BITS_WIDTH + 1;
  localparam int BW  = (ABW > DBW) ? ABW : DBW;
  localparam int CW  = ($clog2(CLK_DIV) < 1) ? 1 : $clog2(CLK_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [ABW-1:0] ADDR_MAX = ABW'(AW);
  localparam logic [DBW-1:0] DATA_MAX = DBW'(DW);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_MODE, S_ADDR, S_DATA_WR, S_STALL, S_DATA_RD, S_HOLD, S_GAP
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   phase_q, phase_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [LEN_WIDTH-1:0]   word_q, word_d;
  logic [ABW-1:0]         abits_q, abits_d;
  logic [DBW-1:0]         dbits_q, dbits_d;
  logic                   wr_q, wr_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [DW-1:0]          sh_q, sh_d;
  logic [DW-1:0]          rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   done_q, done_d;
  logic                   dout_q, dout_d;
  logic                   oe_q, oe_d;
  logic                   cs_q, cs_d;

  logic                   half_end;
  logic                   cell_end;
  logic                   is_cell;
  logic                   word_start;
  logic                   wr_ready;
  logic [DW-1:0]          wr_aligned;

  // Address and write words are left-aligned so the active MSB is always the top bit.
  assign wr_aligned = bus.wr_data << (DATA_MAX - dbits_q);
  assign half_end   = (cnt_q == CNT_LAST);
  assign cell_end   = half_end && phase_q;
  assign is_cell    = (state_q == S_MODE) || (state_q == S_ADDR) ||
                      (state_q == S_DATA_WR) || (state_q == S_DATA_RD);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    word_d     = word_q;
    abits_d    = abits_q;
    dbits_d    = dbits_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    sh_d       = sh_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    dout_d     = dout_q;
    oe_d       = oe_q;
    word_start = 1'b0;
    wr_ready   = 1'b0;

    if (state_q != S_IDLE && state_q != S_STALL) begin
      cnt_d = half_end ? '0 : cnt_q + 1'b1;
    end
    if (is_cell && half_end) begin
      phase_d = ~phase_q;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          phase_d = 1'b0;
          abits_d = bus.addr_bits;
          dbits_d = bus.data_bits;
          wr_d    = bus.cmd_wr;
          addr_d  = bus.cmd_addr << (ADDR_MAX - bus.addr_bits);
          word_d  = bus.cmd_len;
          dout_d  = bus.cmd_wr;
          oe_d    = 1'b1;
        end
      end
      S_SETUP: begin
        if (half_end) state_d = S_MODE;
      end
      S_MODE: begin
        if (cell_end) begin
          state_d = S_ADDR;
          bit_d   = BW'(abits_q) - 1'b1;
          dout_d  = addr_q[AW-1];
        end
      end
      S_ADDR: begin
        if (cell_end) begin
          if (bit_q == '0) begin
            if (wr_q) begin
              word_start = 1'b1;
            end else begin
              state_d = S_DATA_RD;
              oe_d    = 1'b0;
              bit_d   = BW'(dbits_q) - 1'b1;
              sh_d    = '0;
            end
          end else begin
            bit_d  = bit_q - 1'b1;
            addr_d = addr_q << 1;
            dout_d = addr_q[AW-2];
          end
        end
      end
      S_DATA_WR: begin
        if (cell_end) begin
          if (bit_q == '0) begin
            if (word_q == '0) begin
              state_d = S_HOLD;
            end else begin
              word_d     = word_q - 1'b1;
              word_start = 1'b1;
            end
          end else begin
            bit_d  = bit_q - 1'b1;
            sh_d   = sh_q << 1;
            dout_d = sh_q[DW-2];
          end
        end
      end
      S_STALL: begin
        word_start = 1'b1;
      end
      S_DATA_RD: begin
        // The slave drives after the rising edge; sample at the end of the high half.
        if (cell_end) begin
          sh_d = {sh_q[DW-2:0], bus.tw_bus_data_in};
          if (bit_q == '0) begin
            rd_data_d  = {sh_q[DW-2:0], bus.tw_bus_data_in};
            rd_valid_d = 1'b1;
            if (word_q == '0) begin
              state_d = S_HOLD;
            end else begin
              word_d = word_q - 1'b1;
              bit_d  = BW'(dbits_q) - 1'b1;
              sh_d   = '0;
            end
          end else begin
            bit_d = bit_q - 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (half_end) begin
          state_d = S_GAP;
          oe_d    = 1'b0;
          dout_d  = 1'b0;
        end
      end
      S_GAP: begin
        if (half_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Word boundary of a write: load the next word or park with the clock low.
    if (word_start) begin
      if (bus.wr_data_valid) begin
        wr_ready = 1'b1;
        state_d  = S_DATA_WR;
        cnt_d    = '0;
        phase_d  = 1'b0;
        bit_d    = BW'(dbits_q) - 1'b1;
        sh_d     = wr_aligned;
        dout_d   = wr_aligned[DW-1];
      end else begin
        state_d = S_STALL;
      end
    end
  end

  assign cs_d = (state_d == S_IDLE) || (state_d == S_GAP);

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      bit_q      <= '0;
      word_q     <= '0;
      abits_q    <= '0;
      dbits_q    <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      sh_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      dout_q     <= 1'b0;
      oe_q       <= 1'b0;
      cs_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      word_q     <= word_d;
      abits_q    <= abits_d;
      dbits_q    <= dbits_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      sh_q       <= sh_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      cs_q       <= cs_d;
    end
  end

  assign bus.cmd_ready         = (state_q == S_IDLE);
  assign bus.busy              = (state_q != S_IDLE);
  assign bus.wr_data_ready     = wr_ready;
  assign bus.rd_data           = rd_data_q;
  assign bus.rd_data_valid     = rd_valid_q;
  assign bus.done              = done_q;
  assign bus.tw_bus_clock      = phase_q;
  assign bus.tw_bus_chipselect = cs_q;
  assign bus.tw_bus_data_out   = dout_q;
  assign bus.tw_bus_data_oe    = oe_q;
endmodule
